// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control definitions: run-state encodings and default counter width.
// Also used by the top level and the 7-seg display mux.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] RS_OFF    = 2'd0;
  localparam logic [1:0] RS_RUN    = 2'd1;
  localparam logic [1:0] RS_HALTED = 2'd2;
  localparam logic [1:0] RS_RESUME = 2'd3;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, debounce counter and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_reg;
  logic [DW-1:0] db_cnt_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          press_reg;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[0], btn};
  end

  // Accept a new level only after it has differed from the accepted level
  // for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_reg <= '0;
      stable_reg <= 1'b0;
    end else if (sync_reg[1] != stable_reg) begin
      if (db_cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
        stable_reg <= sync_reg[1];
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end else begin
      db_cnt_reg <= '0;
    end
  end

  // One-cycle pulse on each accepted rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d_reg <= 1'b0;
      press_reg    <= 1'b0;
    end else begin
      stable_d_reg <= stable_reg;
      press_reg    <= stable_reg & ~stable_d_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run-control: halt/continue handshake FSM, halt snapshot of the debug
// bus, saturating halt and run-length counters, sticky continue timeout flag.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEBOUNCE_CYC = 4,
  parameter int CONT_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_continue,
  input  logic              cpu_pwr,
  input  logic              cpu_halted,
  input  logic [DATA_W-1:0] cpu_debug,
  output logic              cpu_continue,
  output logic [DATA_W-1:0] debug_latched,
  output logic [CNT_W-1:0]  halt_count,
  output logic [CNT_W-1:0]  last_run_cycles,
  output logic [1:0]        run_state,
  output logic              cont_err
);

  localparam int TW = $clog2(CONT_TIMEOUT + 1);

  logic              press;
  logic              halt_entry;
  logic [1:0]        state_reg;
  logic              cont_reg;
  logic              err_reg;
  logic [TW-1:0]     to_ctr_reg;
  logic [CNT_W-1:0]  run_ctr_reg;
  logic [DATA_W-1:0] debug_reg;
  logic [CNT_W-1:0]  halt_cnt_reg;
  logic [CNT_W-1:0]  last_run_reg;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_continue),
    .press(press)
  );

  // Halt entry happens from RUN, or straight from OFF when power comes up halted.
  // A RESUME timeout returns to HALTED without a new snapshot.
  always_comb begin
    halt_entry = cpu_pwr && cpu_halted &&
                 ((state_reg == RS_RUN) || (state_reg == RS_OFF));
  end

  // Run-state FSM with continue handshake, timeout and run-length counter.
  // Loss of power overrides everything; presses outside HALTED are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RS_OFF;
      cont_reg    <= 1'b0;
      err_reg     <= 1'b0;
      to_ctr_reg  <= '0;
      run_ctr_reg <= '0;
    end else if (!cpu_pwr) begin
      state_reg <= RS_OFF;
      cont_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RS_OFF: begin
          if (cpu_halted) begin
            state_reg <= RS_HALTED;
          end else begin
            state_reg   <= RS_RUN;
            run_ctr_reg <= '0;
          end
        end
        RS_RUN: begin
          if (cpu_halted) state_reg <= RS_HALTED;
          else if (run_ctr_reg != '1) run_ctr_reg <= run_ctr_reg + 1'b1;
        end
        RS_HALTED: begin
          if (press) begin
            state_reg  <= RS_RESUME;
            cont_reg   <= 1'b1;
            to_ctr_reg <= '0;
          end
        end
        RS_RESUME: begin
          if (!cpu_halted) begin
            state_reg   <= RS_RUN;
            cont_reg    <= 1'b0;
            run_ctr_reg <= '0;
          end else if (to_ctr_reg == TW'(CONT_TIMEOUT - 1)) begin
            state_reg <= RS_HALTED;
            cont_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            to_ctr_reg <= to_ctr_reg + 1'b1;
          end
        end
        default: state_reg <= RS_OFF;
      endcase
    end
  end

  // Snapshot the debug bus and update halt statistics on each halt entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_reg    <= '0;
      halt_cnt_reg <= '0;
      last_run_reg <= '0;
    end else if (halt_entry) begin
      debug_reg    <= cpu_debug;
      last_run_reg <= run_ctr_reg;
      if (halt_cnt_reg != '1) halt_cnt_reg <= halt_cnt_reg + 1'b1;
    end
  end

  assign cpu_continue    = cont_reg;
  assign debug_latched   = debug_reg;
  assign halt_count      = halt_cnt_reg;
  assign last_run_cycles = last_run_reg;
  assign run_state       = state_reg;
  assign cont_err        = err_reg;

endmodule
